window_line_ctrl: RTL and testbench

- Parametrised sliding-window line-buffer controller for the convolution datapath.
- Accepts a raster stream of multi-channel pixels and stores rows in K+1 rotating line buffers.
- Emits every valid KxK window, stride 1, no padding, on a registered ready/valid output.
- Upgrade over the fixed 3x3/4-buffer controller: kernel size, image size and channel count are generic, full backpressure on both sides, explicit row/frame markers.

---
 rtl/window_line_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_window_line_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/window_line_ctrl.sv
// Sliding-window line-buffer controller: stores raster rows in K+1 rotating
// line buffers and emits every KxK window (stride 1, no padding) through a
// registered ready/valid output carrying row/frame end markers.
module window_line_ctrl #(
   parameter int unsigned DataWidth = 16,
   parameter int unsigned Ch        = 1,
   parameter int unsigned Width     = 8,
   parameter int unsigned Height    = 8,
   parameter int unsigned K         = 3
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [DataWidth*Ch-1:0]         i_pixel_data,
   input  logic                            i_pixel_data_valid,
   output logic                            o_ready,
   output logic [DataWidth*Ch*K*K-1:0]     o_pixel_data,
   output logic                            o_pixel_data_valid,
   input  logic                            i_ready,
   output logic                            o_row_end,
   output logic                            o_frame_end
);

   localparam int unsigned PixW    = DataWidth * Ch;
   localparam int unsigned WinW    = PixW * K * K;
   localparam int unsigned NBuf    = K + 1;
   localparam int unsigned ColIdxW = (Width > 1) ? $clog2(Width) : 1;
   localparam int unsigned RowW    = (Height > 1) ? $clog2(Height) : 1;
   localparam int unsigned BufW    = $clog2(NBuf);
   localparam int unsigned FillW   = $clog2(NBuf + 1);

   localparam logic [ColIdxW-1:0] LastWrCol  = ColIdxW'(Width - 1);
   localparam logic [ColIdxW-1:0] LastRdCol  = ColIdxW'(Width - K);
   localparam logic [RowW-1:0]    LastWrRow  = RowW'(Height - 1);
   localparam logic [RowW-1:0]    LastOutRow = RowW'(Height - K);
   localparam logic [FillW-1:0]   FullCnt    = FillW'(NBuf);
   localparam logic [FillW-1:0]   KCnt       = FillW'(K);

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   // Modular add on the line-buffer ring
   function automatic logic [BufW-1:0] buf_add(input logic [BufW-1:0] base,
                                               input int unsigned      off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= NBuf) begin
         sum = sum - NBuf;
      end
      return BufW'(sum);
   endfunction

   // Line storage (no reset: contents are don't-care after reset)
   logic [PixW-1:0] line_mem [NBuf][Width];

   state_e              state_q, state_d;
   logic [ColIdxW-1:0]  wr_col_q, wr_col_d;
   logic [BufW-1:0]     wr_buf_q, wr_buf_d;
   logic [RowW-1:0]     wr_row_q, wr_row_d;
   logic [FillW-1:0]    filled_q, filled_d;
   logic [BufW-1:0]     rd_buf_q, rd_buf_d;
   logic [ColIdxW-1:0]  rd_col_q, rd_col_d;
   logic [RowW-1:0]     out_row_q, out_row_d;
   logic                iss_done_q, iss_done_d;
   logic                ready_q, ready_d;
   logic                valid_q, valid_d;
   logic [WinW-1:0]     data_q, data_d;
   logic                row_end_q, row_end_d;
   logic                frame_end_q, frame_end_d;

   logic                acc_in_c;
   logic                acc_out_c;
   logic                line_done_c;
   logic                release_c;
   logic                clear_c;
   logic                avail_c;
   logic                load_c;
   logic                load_row_end_c;
   int unsigned         lines_done_c;
   logic [WinW-1:0]     win_c;

   // Write one accepted beat into the current line buffer
   always_ff @(posedge i_clk) begin
      if (acc_in_c) begin
         line_mem[wr_buf_q][wr_col_q] <= i_pixel_data;
      end
   end

   // Gather the KxK window at the issue position; row 0 is the oldest line
   always_comb begin
      win_c = '0;
      for (int unsigned r = 0; r < K; r++) begin
         for (int unsigned c = 0; c < K; c++) begin
            win_c[(r*K + c)*PixW +: PixW] =
               line_mem[buf_add(rd_buf_q, r)][ColIdxW'(32'(rd_col_q) + c)];
         end
      end
   end

   // Next-state logic for pointers, fill level, FSM and output register
   always_comb begin
      state_d     = state_q;
      wr_col_d    = wr_col_q;
      wr_buf_d    = wr_buf_q;
      wr_row_d    = wr_row_q;
      filled_d    = filled_q;
      rd_buf_d    = rd_buf_q;
      rd_col_d    = rd_col_q;
      out_row_d   = out_row_q;
      iss_done_d  = iss_done_q;
      valid_d     = valid_q;
      data_d      = data_q;
      row_end_d   = row_end_q;
      frame_end_d = frame_end_q;
      ready_d     = ready_q;

      acc_in_c    = i_pixel_data_valid && ready_q;
      acc_out_c   = valid_q && i_ready;
      line_done_c = acc_in_c && (wr_col_q == LastWrCol);
      release_c   = acc_out_c && row_end_q;
      clear_c     = acc_out_c && frame_end_q;

      // Complete lines written so far this frame; DRAIN means all of them
      lines_done_c = (state_q == ST_DRAIN) ? Height : 32'(wr_row_q);
      avail_c      = !iss_done_q && (lines_done_c >= 32'(out_row_q) + K);
      load_c       = avail_c && (!valid_q || i_ready);
      load_row_end_c = (rd_col_q == LastRdCol);

      // Write side pointers
      if (acc_in_c) begin
         if (line_done_c) begin
            wr_col_d = '0;
            wr_buf_d = buf_add(wr_buf_q, 1);
            if (wr_row_q != LastWrRow) begin
               wr_row_d = wr_row_q + RowW'(1);
            end
         end else begin
            wr_col_d = wr_col_q + ColIdxW'(1);
         end
      end

      // Held-line count: completion adds, release of the oldest line subtracts
      case ({line_done_c, release_c})
         2'b10:   filled_d = filled_q + FillW'(1);
         2'b01:   filled_d = filled_q - FillW'(1);
         default: filled_d = filled_q;
      endcase

      // Issue side: load next window, advancing to the next row base at row end
      if (load_c) begin
         valid_d     = 1'b1;
         data_d      = win_c;
         row_end_d   = load_row_end_c;
         frame_end_d = load_row_end_c && (out_row_q == LastOutRow);
         if (load_row_end_c) begin
            rd_col_d = '0;
            rd_buf_d = buf_add(rd_buf_q, 1);
            if (out_row_q == LastOutRow) begin
               iss_done_d = 1'b1;
            end else begin
               out_row_d = out_row_q + RowW'(1);
            end
         end else begin
            rd_col_d = rd_col_q + ColIdxW'(1);
         end
      end else if (acc_out_c) begin
         valid_d = 1'b0;
      end

      // FSM transitions
      case (state_q)
         ST_FILL: begin
            if (filled_q >= KCnt) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: state_d = ST_STREAM;
         ST_DRAIN:  state_d = ST_DRAIN;
         default:   state_d = ST_FILL;
      endcase
      if (line_done_c && (wr_row_q == LastWrRow)) begin
         state_d = ST_DRAIN;
      end

      // Frame end accepted: start over for the next frame (overrides all above)
      if (clear_c) begin
         state_d    = ST_FILL;
         wr_col_d   = '0;
         wr_buf_d   = '0;
         wr_row_d   = '0;
         filled_d   = '0;
         rd_buf_d   = '0;
         rd_col_d   = '0;
         out_row_d  = '0;
         iss_done_d = 1'b0;
         valid_d    = 1'b0;
      end

      ready_d = (state_d != ST_DRAIN) && (filled_d < FullCnt);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_FILL;
         wr_col_q    <= '0;
         wr_buf_q    <= '0;
         wr_row_q    <= '0;
         filled_q    <= '0;
         rd_buf_q    <= '0;
         rd_col_q    <= '0;
         out_row_q   <= '0;
         iss_done_q  <= 1'b0;
         ready_q     <= 1'b1;
         valid_q     <= 1'b0;
         data_q      <= '0;
         row_end_q   <= 1'b0;
         frame_end_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_col_q    <= wr_col_d;
         wr_buf_q    <= wr_buf_d;
         wr_row_q    <= wr_row_d;
         filled_q    <= filled_d;
         rd_buf_q    <= rd_buf_d;
         rd_col_q    <= rd_col_d;
         out_row_q   <= out_row_d;
         iss_done_q  <= iss_done_d;
         ready_q     <= ready_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         row_end_q   <= row_end_d;
         frame_end_q <= frame_end_d;
      end
   end

   assign o_ready            = ready_q;
   assign o_pixel_data_valid = valid_q;
   assign o_pixel_data       = data_q;
   assign o_row_end          = row_end_q;
   assign o_frame_end        = frame_end_q;

endmodule

// File: tb/tb_window_line_ctrl.sv
// Bench for window_line_ctrl: three configurations driven with random and
// patterned images, windows compared against a frame-array reference model.
module tb_window_line_ctrl;

   logic clk;
   logic rst;

   // Config A: 4x4, K=3, Ch=1
   logic [15:0]  a_data;
   logic         a_vld, a_ordy, a_ovld, a_irdy, a_rend, a_fend;
   logic [143:0] a_out;
   // Config B: 4 wide, 6 high, K=3, Ch=1
   logic [15:0]  b_data;
   logic         b_vld, b_ordy, b_ovld, b_irdy, b_rend, b_fend;
   logic [143:0] b_out;
   // Config C: 6 wide, 5 high, K=5, Ch=2
   logic [31:0]  c_data;
   logic         c_vld, c_ordy, c_ovld, c_irdy, c_rend, c_fend;
   logic [799:0] c_out;

   int n_vec = 0;
   int n_err = 0;

   // Reference image store: [frame][row][col][channel]
   logic [15:0] img [2][8][8][2];

   window_line_ctrl #(.DataWidth(16), .Ch(1), .Width(4), .Height(4), .K(3)) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_pixel_data(a_data), .i_pixel_data_valid(a_vld),
      .o_ready(a_ordy), .o_pixel_data(a_out), .o_pixel_data_valid(a_ovld),
      .i_ready(a_irdy), .o_row_end(a_rend), .o_frame_end(a_fend));

   window_line_ctrl #(.DataWidth(16), .Ch(1), .Width(4), .Height(6), .K(3)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_pixel_data(b_data), .i_pixel_data_valid(b_vld),
      .o_ready(b_ordy), .o_pixel_data(b_out), .o_pixel_data_valid(b_ovld),
      .i_ready(b_irdy), .o_row_end(b_rend), .o_frame_end(b_fend));

   window_line_ctrl #(.DataWidth(16), .Ch(2), .Width(6), .Height(5), .K(5)) u_dut_c (
      .i_clk(clk), .i_rst(rst), .i_pixel_data(c_data), .i_pixel_data_valid(c_vld),
      .o_ready(c_ordy), .o_pixel_data(c_out), .o_pixel_data_valid(c_ovld),
      .i_ready(c_irdy), .o_row_end(c_rend), .o_frame_end(c_fend));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports
   task automatic check_val(input string tag, input logic [799:0] got, input logic [799:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected window from the image store, element (r,c,ch) packed raster order
   function automatic logic [799:0] exp_win(input int f, input int k, input int nch,
                                            input int orow, input int ocol);
      logic [799:0] w;
      w = '0;
      for (int r = 0; r < k; r++)
         for (int c = 0; c < k; c++)
            for (int ch = 0; ch < nch; ch++)
               w[((r*k + c)*nch + ch)*16 +: 16] = img[f][orow + r][ocol + c][ch];
      return w;
   endfunction

   task automatic fill_pattern(input int f);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            img[f][r][c][0] = 16'(r*4 + c);
            img[f][r][c][1] = 16'(16'h100 + r*4 + c);
         end
   endtask

   task automatic fill_random(input int f);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            for (int ch = 0; ch < 2; ch++)
               img[f][r][c][ch] = 16'($urandom);
   endtask

   // Drive config A inputs for the next beat; called at posedge+1
   task automatic drive_a(input int beat, input int total, input int vmode, input int rmode);
      a_vld = (beat < total) && ((vmode == 0) || ($urandom_range(0, 3) != 0));
      if (beat < total) a_data = img[beat/16][(beat%16)/4][beat%4][0];
      if (rmode == 0)      a_irdy = 1'b1;
      else if (rmode == 1) a_irdy = ~a_irdy;
      else                 a_irdy = 1'($urandom_range(0, 1));
   endtask

   // Stream nfr frames through config A, checking every presented window
   task automatic run_a(input int nfr, input int rmode, input int vmode,
                        input int stop_win, input bit check_lat);
      int beat = 0, nwin = 0, cyc = 0, acc11 = -1, first_v = -1;
      int total_beats = nfr * 16;
      int total_win = nfr * 4;
      int want_win;
      bit prev_stall = 0, just_clr = 0;
      a_irdy = 1'b0;
      drive_a(beat, total_beats, vmode, (rmode == 1) ? 1 : rmode);
      while (nwin < total_win && nwin < stop_win && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (prev_stall) check_val("a_valid_held", a_ovld, 1'b1);
         if (just_clr) check_val("a_ready_after_frame", a_ordy, 1'b1);
         just_clr = 0;
         if (beat >= (nwin/4 + 1)*16) check_val("a_ready_drain", a_ordy, 1'b0);
         if (a_ovld) begin
            check_val("a_window", a_out, exp_win(nwin/4, 3, 1, (nwin%4)/2, nwin%2));
            check_val("a_markers", {a_rend, a_fend}, {nwin%2 == 1, nwin%4 == 3});
            if (first_v < 0) first_v = cyc;
         end
         prev_stall = a_ovld && !a_irdy;
         if (a_ovld && a_irdy) begin
            if (nwin%4 == 3) just_clr = 1;
            nwin++;
         end
         if (a_vld && a_ordy) begin
            if (beat == 11) acc11 = cyc;
            beat++;
         end
         @(posedge clk); #1;
         drive_a(beat, total_beats, vmode, rmode);
      end
      want_win = (stop_win < total_win) ? stop_win : total_win;
      check_val("a_window_count", 32'(nwin), 32'(want_win));
      if (check_lat) check_val("a_first_latency", 32'(first_v - acc11), 32'd2);
      @(posedge clk); #1;
      a_vld = 1'b0;
      a_irdy = 1'b0;
   endtask

   initial begin
      int bb, cb, cw, cextra;
      rst = 1'b1;
      a_vld = 0; a_irdy = 0; a_data = '0;
      b_vld = 0; b_irdy = 0; b_data = '0;
      c_vld = 0; c_irdy = 0; c_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("rst_valid", a_ovld, 1'b0);
      check_val("rst_ready", {a_ordy, b_ordy, c_ordy}, 3'b111);
      check_val("rst_data", a_out, '0);
      check_val("rst_markers", {a_rend, a_fend}, 2'b00);
      @(posedge clk); #1;

      // Directed raster pattern, full throughput, first-window latency
      fill_pattern(0);
      run_a(1, 0, 0, 99, 1'b1);
      // Same frame with downstream ready toggling every cycle
      run_a(1, 1, 0, 99, 1'b0);
      // Two back-to-back identical frames
      fill_pattern(1);
      run_a(2, 0, 0, 99, 1'b0);

      // Downstream fully stalled: input must stop once K+1 lines are held
      bb = 0;
      b_vld = 1'b1; b_irdy = 1'b0; b_data = 16'(bb);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!b_ordy) break;
         if (b_vld && b_ordy) bb++;
         @(posedge clk); #1;
         b_data = 16'(bb);
      end
      check_val("b_beats_until_full", 32'(bb), 32'd16);
      repeat (3) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_val("b_ready_held_low", b_ordy, 1'b0);
      end
      @(posedge clk); #1;
      b_irdy = 1'b1;
      @(negedge clk);
      check_val("b_win0", b_out, exp_win(0, 3, 1, 0, 0));
      check_val("b_win0_valid", {b_ovld, b_rend}, 2'b10);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("b_win1", b_out, exp_win(0, 3, 1, 0, 1));
      check_val("b_win1_row_end", {b_ovld, b_rend, b_ordy}, 3'b110);
      @(posedge clk); #1;
      b_irdy = 1'b0;
      @(negedge clk);
      check_val("b_ready_after_release", b_ordy, 1'b1);
      @(posedge clk); #1;
      b_vld = 1'b0;

      // Reset in the middle of streaming, then a fresh frame
      fill_random(0);
      run_a(1, 0, 0, 2, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_val("midrst_valid_ready", {a_ovld, a_ordy}, 2'b01);
      check_val("midrst_data", a_out, '0);
      @(posedge clk); #1;
      fill_random(0);
      run_a(1, 0, 0, 99, 1'b0);

      // Config C: K=5 with two channels per pixel
      fill_random(0);
      cb = 0; cw = 0; cextra = 0;
      c_irdy = 1'b1;
      c_vld = 1'b1;
      c_data = {img[0][0][0][1], img[0][0][0][0]};
      for (int i = 0; i < 200 && cw < 2; i++) begin
         @(negedge clk);
         if (c_ovld) begin
            check_val("c_window", c_out, exp_win(0, 5, 2, 0, cw));
            check_val("c_markers", {c_rend, c_fend}, {cw == 1, cw == 1});
            cw++;
         end
         if (c_vld && c_ordy) cb++;
         @(posedge clk); #1;
         c_vld = (cb < 30);
         if (cb < 30) c_data = {img[0][cb/6][cb%6][1], img[0][cb/6][cb%6][0]};
      end
      c_vld = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (c_ovld) cextra++;
         @(posedge clk); #1;
      end
      check_val("c_window_count", 32'(cw + cextra), 32'd2);
      check_val("c_ready_idle", c_ordy, 1'b1);

      // Random images, random input gaps and random downstream stalls
      for (int t = 0; t < 4; t++) begin
         fill_random(0);
         fill_random(1);
         run_a(2, 2, 1, 99, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
